// File: rtl/tdc_pkg.sv
// tdc_pkg: shared TDC constants, fine-width helper and timestamp layout.
//   TDC_N        default CARRY4 block count (also used by the pulse generator)
//   TDC_TAP_W    taps in the sampled chain
//   TDC_FINE_W   width able to hold a tap count of 0..TDC_TAP_W
//   tdc_ts_t     packed {coarse, fine} timestamp at default widths
package tdc_pkg;
    localparam int TDC_N = 32;
    localparam int TDC_TAP_W = 4 * TDC_N;
    localparam int TDC_COARSE_W = 24;
    localparam int TDC_DROP_W = 8;

    function automatic int tdc_clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    localparam int TDC_FINE_W = tdc_clog2(TDC_TAP_W + 1);

    typedef struct packed {
        logic [TDC_COARSE_W-1:0] coarse;
        logic [TDC_FINE_W-1:0]   fine;
    } tdc_ts_t;
endpackage

// File: rtl/tdc_popcount.sv
// tdc_popcount: combinational count of ones across the sampled tap vector.
//   taps   in  TAP_W   sampled thermometer (bubbles allowed)
//   count  out FINE_W  number of set taps, 0..TAP_W
module tdc_popcount
    import tdc_pkg::*;
#(
    parameter int TAP_W  = TDC_TAP_W,
    parameter int FINE_W = tdc_clog2(TAP_W + 1)
) (
    input  logic [TAP_W-1:0]  taps,
    output logic [FINE_W-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < TAP_W; i++)
            count = count + FINE_W'(taps[i]);
    end
endmodule

// File: rtl/tdc_capture.sv
// tdc_capture: samples the carry-chain taps, detects hits and emits timestamps.
//   clk, rst   sampling clock, synchronous active-high reset
//   taps       raw chain outputs (asynchronous), tap 0 nearest chain input
//   arm        enables hit detection
//   ts_valid/ts_ready/ts_fine/ts_coarse  single-entry timestamp output port
//   ts_drop    one-cycle pulse when a hit is lost to a full, stalled output
//   drop_cnt   saturating count of lost hits
module tdc_capture
    import tdc_pkg::*;
#(
    parameter int N        = TDC_N,
    parameter int COARSE_W = TDC_COARSE_W,
    parameter int DROP_W   = TDC_DROP_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [4*N-1:0]                    taps,
    input  logic                              arm,
    output logic                              ts_valid,
    input  logic                              ts_ready,
    output logic [tdc_clog2(4*N+1)-1:0]       ts_fine,
    output logic [COARSE_W-1:0]               ts_coarse,
    output logic                              ts_drop,
    output logic [DROP_W-1:0]                 drop_cnt
);
    localparam int TAP_W  = 4 * N;
    localparam int FINE_W = tdc_clog2(TAP_W + 1);

    // s0 is the metastability stage; only s1 is ever decoded.
    logic [TAP_W-1:0]    s0, s1;
    logic [COARSE_W-1:0] cnt, c0, c1;
    logic                tap0_prev;
    logic [FINE_W-1:0]   fine;
    logic                hit, load, drop;

    tdc_popcount #(.TAP_W(TAP_W), .FINE_W(FINE_W)) u_pop (
        .taps  (s1),
        .count (fine)
    );

    // c1 tracks s1 so the coarse stamp matches the edge that captured the taps.
    assign hit  = arm && s1[0] && !tap0_prev;
    assign load = hit && (!ts_valid || ts_ready);
    assign drop = hit && ts_valid && !ts_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0        <= '0;
            s1        <= '0;
            tap0_prev <= 1'b0;
            cnt       <= '0;
            c0        <= '0;
            c1        <= '0;
            ts_valid  <= 1'b0;
            ts_fine   <= '0;
            ts_coarse <= '0;
            ts_drop   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            s0        <= taps;
            s1        <= s0;
            tap0_prev <= s1[0];
            cnt       <= cnt + COARSE_W'(1);
            c0        <= cnt;
            c1        <= c0;
            ts_drop   <= drop;
            if (load) begin
                ts_valid  <= 1'b1;
                ts_fine   <= fine;
                ts_coarse <= c1;
            end else if (ts_ready) begin
                ts_valid <= 1'b0;
            end
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end
endmodule

// File: tb/tb_tdc_capture.sv
// tb_tdc_capture: directed and randomized checks of tdc_capture (COARSE_W = 4).
module tb_tdc_capture;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  taps = '0;
    logic          arm = 1'b0;
    logic          ts_ready = 1'b0;
    logic          ts_valid;
    logic [7:0]    ts_fine;
    logic [CW-1:0] ts_coarse;
    logic          ts_drop;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int fails = 0;

    // Reference: history of applied taps indexed by edges since reset release.
    logic [127:0]  h1, h2, h3;
    int            e;
    logic          m_valid, m_drop;
    logic [7:0]    m_fine;
    logic [CW-1:0] m_coarse;
    int            m_drops;

    tdc_capture #(.N(32), .COARSE_W(CW), .DROP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .taps      (taps),
        .arm       (arm),
        .ts_valid  (ts_valid),
        .ts_ready  (ts_ready),
        .ts_fine   (ts_fine),
        .ts_coarse (ts_coarse),
        .ts_drop   (ts_drop),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Apply inputs for one edge, advance the reference, return at the negedge.
    task automatic tick(input logic [127:0] t, input logic a, input logic r, input logic rs);
        logic hit;
        taps = t;
        arm = a;
        ts_ready = r;
        rst = rs;
        @(posedge clk);
        if (rs) begin
            h1 = '0; h2 = '0; h3 = '0; e = 0;
            m_valid = 0; m_drop = 0; m_fine = 0; m_coarse = 0; m_drops = 0;
        end else begin
            // A hit is a rising tap 0 captured two edges ago, gated by arm now.
            hit = a && h2[0] && !h3[0];
            m_drop = hit && m_valid && !r;
            if (hit && (!m_valid || r)) begin
                m_valid = 1;
                m_fine = 8'($countones(h2));
                m_coarse = CW'(e - 2);
            end else if (m_valid && r) begin
                m_valid = 0;
            end
            if (m_drop) m_drops++;
            h3 = h2; h2 = h1; h1 = t; e++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick('0, 1, 0, 1);
        tick('0, 1, 0, 1);
        checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0h want 0", ts_valid); end
        checks++; if (ts_fine !== 8'd0) begin fails++; $display("FAIL reset_fine: got %0h want 0", ts_fine); end
        checks++; if (ts_coarse !== 4'd0) begin fails++; $display("FAIL reset_coarse: got %0h want 0", ts_coarse); end
        checks++; if (ts_drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %0h want 0", ts_drop); end
        checks++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop_cnt: got %0h want 0", drop_cnt); end
    endtask

    task automatic test_basic();
        tick('0, 1, 0, 1);
        for (int i = 0; i < 10; i++) tick('0, 1, 0, 0);
        tick(128'hFF, 1, 0, 0);
        tick(128'hFF, 1, 0, 0);
        checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL basic_early: got %0h want 0", ts_valid); end
        tick(128'hFF, 1, 0, 0);
        checks++; if (ts_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0h want 1", ts_valid); end
        checks++; if (ts_fine !== 8'd8) begin fails++; $display("FAIL basic_fine: got %0d want 8", ts_fine); end
        checks++; if (ts_coarse !== 4'd10) begin fails++; $display("FAIL basic_coarse: got %0d want 10", ts_coarse); end
        tick('0, 1, 1, 0);
        checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL basic_accept: got %0h want 0", ts_valid); end
    endtask

    task automatic test_all_ones();
        int n = 0;
        logic [7:0] f = '0;
        for (int i = 0; i < 3; i++) tick('0, 1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            tick('1, 1, 1, 0);
            if (ts_valid) begin n++; f = ts_fine; end
        end
        checks++; if (n !== 1) begin fails++; $display("FAIL ones_count: got %0d want 1", n); end
        checks++; if (f !== 8'd128) begin fails++; $display("FAIL ones_fine: got %0d want 128", f); end
        for (int i = 0; i < 3; i++) tick('0, 1, 1, 0);
        for (int i = 0; i < 3; i++) tick(128'hF7, 1, 1, 0);
        checks++; if (ts_valid !== 1'b1) begin fails++; $display("FAIL bubble_valid: got %0h want 1", ts_valid); end
        checks++; if (ts_fine !== 8'd7) begin fails++; $display("FAIL bubble_fine: got %0d want 7", ts_fine); end
    endtask

    task automatic test_drop();
        logic [127:0] pat [10] = '{0, 0, 3, 0, 0, 0, 5, 0, 0, 0};
        int pulses = 0;
        tick('0, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tick(pat[i], 1, 0, 0);
            if (ts_drop) pulses++;
        end
        checks++; if (pulses !== 1) begin fails++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
        checks++; if (drop_cnt !== 8'd1) begin fails++; $display("FAIL drop_cnt1: got %0d want 1", drop_cnt); end
        checks++; if (ts_fine !== 8'd2) begin fails++; $display("FAIL drop_hold_fine: got %0d want 2", ts_fine); end
        checks++; if (ts_coarse !== 4'd2) begin fails++; $display("FAIL drop_hold_coarse: got %0d want 2", ts_coarse); end
        for (int i = 0; i < 300; i++) begin
            tick(128'h1, 1, 0, 0);
            tick('0, 1, 0, 0);
        end
        checks++; if (drop_cnt !== 8'd255) begin fails++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
        checks++; if (ts_valid !== 1'b1) begin fails++; $display("FAIL drop_still_valid: got %0h want 1", ts_valid); end
    endtask

    task automatic test_back_to_back();
        tick('0, 1, 0, 1);
        tick('0, 1, 0, 0);
        tick('0, 1, 0, 0);
        tick(128'h3, 1, 0, 0);
        tick('0, 1, 0, 0);
        tick('0, 1, 0, 0);
        checks++; if (ts_valid !== 1'b1) begin fails++; $display("FAIL b2b_first: got %0h want 1", ts_valid); end
        tick(128'h7, 1, 0, 0);
        tick('0, 1, 0, 0);
        tick('0, 1, 1, 0);
        checks++; if (ts_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %0h want 1", ts_valid); end
        checks++; if (ts_fine !== 8'd3) begin fails++; $display("FAIL b2b_fine: got %0d want 3", ts_fine); end
        checks++; if (ts_coarse !== 4'd5) begin fails++; $display("FAIL b2b_coarse: got %0d want 5", ts_coarse); end
        checks++; if (ts_drop !== 1'b0) begin fails++; $display("FAIL b2b_drop: got %0h want 0", ts_drop); end
        tick('0, 1, 1, 0);
        checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %0h want 0", ts_valid); end
    endtask

    task automatic test_arm();
        int n = 0;
        tick('0, 1, 0, 1);
        tick('0, 1, 0, 0);
        tick('0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick(128'h1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(128'h1, 1, 0, 0);
            if (ts_valid) n++;
        end
        checks++; if (n !== 0 || ts_valid !== 1'b0) begin fails++; $display("FAIL arm_ignored: got %0d stamps want 0", n); end
        tick('0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick(128'h1, 1, 0, 0);
        checks++; if (ts_valid !== 1'b1) begin fails++; $display("FAIL arm_rearmed: got %0h want 1", ts_valid); end
        checks++; if (ts_coarse !== 4'd10) begin fails++; $display("FAIL arm_coarse: got %0d want 10", ts_coarse); end
    endtask

    task automatic test_wrap();
        tick('0, 1, 1, 1);
        for (int i = 0; i < 15; i++) tick('0, 1, 1, 0);
        tick(128'h1, 1, 1, 0);
        tick('0, 1, 1, 0);
        tick(128'h1, 1, 1, 0);
        checks++; if (ts_valid !== 1'b1 || ts_coarse !== 4'd15) begin fails++; $display("FAIL wrap_15: got v=%0h c=%0d want v=1 c=15", ts_valid, ts_coarse); end
        tick('0, 1, 1, 0);
        tick('0, 1, 1, 0);
        checks++; if (ts_valid !== 1'b1 || ts_coarse !== 4'd1) begin fails++; $display("FAIL wrap_1: got v=%0h c=%0d want v=1 c=1", ts_valid, ts_coarse); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pat [7] = '{0, 0, 1, 0, 1, 0, 0};
        int n = 0;
        tick('0, 1, 0, 1);
        for (int i = 0; i < 7; i++) tick(pat[i], 1, 0, 0);
        checks++; if (ts_valid !== 1'b1 || drop_cnt !== 8'd1) begin fails++; $display("FAIL rmid_setup: got v=%0h d=%0d want v=1 d=1", ts_valid, drop_cnt); end
        tick('0, 1, 0, 1);
        checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %0h want 0", ts_valid); end
        checks++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL rmid_drop_cnt: got %0d want 0", drop_cnt); end
        for (int i = 0; i < 3; i++) begin
            tick('0, 1, 0, 0);
            if (ts_valid) n++;
        end
        checks++; if (n !== 0) begin fails++; $display("FAIL rmid_quiet: got %0d stamps want 0", n); end
    endtask

    task automatic test_random();
        tick('0, 1, 0, 1);
        for (int i = 0; i < 600; i++) begin
            tick({$urandom, $urandom, $urandom, $urandom}, ($urandom % 8) != 0,
                 ($urandom % 3) != 0, ($urandom % 150) == 0);
            checks++; if (ts_valid !== m_valid) begin fails++; $display("FAIL rand_valid @%0d: got %0h want %0h", i, ts_valid, m_valid); end
            checks++; if (ts_drop !== m_drop) begin fails++; $display("FAIL rand_drop @%0d: got %0h want %0h", i, ts_drop, m_drop); end
            checks++; if (drop_cnt !== 8'(m_drops > 255 ? 255 : m_drops)) begin fails++; $display("FAIL rand_drop_cnt @%0d: got %0d want %0d", i, drop_cnt, m_drops); end
            checks++; if (m_valid && ts_fine !== m_fine) begin fails++; $display("FAIL rand_fine @%0d: got %0d want %0d", i, ts_fine, m_fine); end
            checks++; if (m_valid && ts_coarse !== m_coarse) begin fails++; $display("FAIL rand_coarse @%0d: got %0d want %0d", i, ts_coarse, m_coarse); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_drop();
        test_back_to_back();
        test_arm();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
